// File: rtl/inst_cache_if.sv
// Fetch-side and memory-controller-side signal bundle for inst_cache.
// The slave modport is the cache; the master modport is the IF stage plus the memory controller.
`timescale 1ns/1ps
interface inst_cache_if;
    logic        rdy_in;
    logic        req_in;
    logic [17:0] addr_in;
    logic        flush_in;
    logic        instE_out;
    logic [31:0] inst_out;
    logic        mc_req_out;
    logic [17:0] mc_addr_out;
    logic        mc_busy_in;
    logic        mc_valid_in;
    logic [7:0]  mc_data_in;

    modport slave (
        input  rdy_in, req_in, addr_in, flush_in, mc_busy_in, mc_valid_in, mc_data_in,
        output instE_out, inst_out, mc_req_out, mc_addr_out
    );

    modport master (
        output rdy_in, req_in, addr_in, flush_in, mc_busy_in, mc_valid_in, mc_data_in,
        input  instE_out, inst_out, mc_req_out, mc_addr_out
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-line instruction cache, byte-serial refill from the memory controller.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
`timescale 1ns/1ps
module inst_cache #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic         clk_in,
    input  logic         rst_in,
    inst_cache_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt_out,
    output logic [31:0]  miss_cnt_out
`endif
);
    localparam int unsigned Lines   = 2 ** INDEX_BITS;
    localparam int unsigned TagBits = 16 - INDEX_BITS;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e               state_q, state_d;
    logic [Lines-1:0]     valid_q, valid_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [17:0]          base_q, base_d;
    logic [31:0]          buf_q, buf_d;
    logic                 inst_e_q, inst_e_d;
    logic [31:0]          inst_q, inst_d;
    logic [17:0]          mc_addr_q, mc_addr_d;
    logic                 line_we;

    logic [31:0]          data_mem [Lines];
    logic [TagBits-1:0]   tag_mem  [Lines];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TagBits-1:0]    req_tag, fill_tag;
    logic                  hit;
    logic                  unused_addr;

    assign req_idx     = bus.addr_in[INDEX_BITS+1:2];
    assign req_tag     = bus.addr_in[17:INDEX_BITS+2];
    assign fill_idx    = base_q[INDEX_BITS+1:2];
    assign fill_tag    = base_q[17:INDEX_BITS+2];
    assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_addr = ^bus.addr_in[1:0];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        buf_d     = buf_q;
        inst_e_d  = 1'b0;
        inst_d    = inst_q;
        mc_addr_d = mc_addr_q;
        line_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_in && !bus.flush_in) begin
                    if (hit) begin
                        inst_e_d = 1'b1;
                        inst_d   = data_mem[req_idx];
                    end else begin
                        base_d    = {bus.addr_in[17:2], 2'b00};
                        mc_addr_d = {bus.addr_in[17:2], 2'b00};
                        cnt_d     = 2'd0;
                        state_d   = StFill;
                    end
                end
            end
            StFill: begin
                if (bus.mc_valid_in) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = bus.mc_data_in;
                    if (cnt_q == 2'd3) begin
                        // A coincident flush still commits the completed line, but serves nothing.
                        line_we           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        state_d           = StIdle;
                        inst_e_d          = !bus.flush_in;
                        if (!bus.flush_in) begin
                            inst_d = buf_d;
                        end
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        mc_addr_d = base_q + {16'd0, cnt_q + 2'd1};
                    end
                end
                if (bus.flush_in) begin
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            cnt_q     <= 2'd0;
            base_q    <= '0;
            buf_q     <= '0;
            inst_e_q  <= 1'b0;
            inst_q    <= '0;
            mc_addr_q <= '0;
        end else if (bus.rdy_in) begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            buf_q     <= buf_d;
            inst_e_q  <= inst_e_d;
            inst_q    <= inst_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    // Data and tag arrays are deliberately left uninitialised; valid_q guards them.
    always_ff @(posedge clk_in) begin
        if (bus.rdy_in && line_we) begin
            data_mem[fill_idx] <= buf_d;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    assign bus.instE_out   = inst_e_q;
    assign bus.inst_out    = inst_q;
    assign bus.mc_req_out  = (state_q == StFill) && !bus.mc_busy_in;
    assign bus.mc_addr_out = mc_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        accept;

    assign accept = (state_q == StIdle) && bus.req_in && !bus.flush_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (bus.rdy_in && accept) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_out  = hit_cnt_q;
    assign miss_cnt_out = miss_cnt_q;
`endif

endmodule
